// File: rtl/tug_of_war_match_if.sv
// tug_of_war_match_if: game-tick, player, cpu and display signals of the tug-of-war engine
// master: drives ce, btn_left, btn_right, start, cpu_enable, cpu_level; slave: drives led, scores, match_over, winner
interface tug_of_war_match_if #(
  parameter int NUM_LEDS = 9,
  parameter int POINTS_TO_WIN = 7
);
  localparam int SW = $clog2(POINTS_TO_WIN + 1);
  logic ce;
  logic btn_left;
  logic btn_right;
  logic start;
  logic cpu_enable;
  logic [3:0] cpu_level;
  logic [NUM_LEDS-1:0] led;
  logic [SW-1:0] score_left;
  logic [SW-1:0] score_right;
  logic match_over;
  logic winner;
  modport master (
    output ce, btn_left, btn_right, start, cpu_enable, cpu_level,
    input led, score_left, score_right, match_over, winner
  );
  modport slave (
    input ce, btn_left, btn_right, start, cpu_enable, cpu_level,
    output led, score_left, score_right, match_over, winner
  );
endinterface

// File: rtl/tug_of_war_match.sv
// tug_of_war_match: multi-point tug-of-war engine with point hold phase and LFSR computer opponent
// ports: clk, reset (async active-low), bus (slave: ce/buttons/start/cpu in, led/scores/match_over/winner out)
module tug_of_war_match #(
  parameter int NUM_LEDS = 9,
  parameter int POINTS_TO_WIN = 7,
  parameter int HOLD_TICKS = 8
) (
  input logic clk,
  input logic reset,
  tug_of_war_match_if.slave bus
);
  localparam int SW = $clog2(POINTS_TO_WIN + 1);
  localparam int CENTER = NUM_LEDS / 2;
  localparam int PW = $clog2(NUM_LEDS);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [NUM_LEDS-1:0] CENTER_LED = NUM_LEDS'(1) << CENTER;
  localparam logic [NUM_LEDS-1:0] LEFT_EDGE = NUM_LEDS'(1) << (NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] RIGHT_EDGE = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] RIGHT_WIN = (NUM_LEDS'(1) << CENTER) - NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LEFT_WIN = ~((NUM_LEDS'(1) << (CENTER + 1)) - NUM_LEDS'(1));
  typedef enum logic [1:0] {IDLE, PLAY, POINT, MATCH_OVER} state_t;
  state_t state;
  logic [1:0] sync_l, sync_r;
  logic sl, sr;
  logic [15:0] lfsr;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold;
  logic scorer;
  logic [NUM_LEDS-1:0] led;
  logic [SW-1:0] score_l, score_r;
  logic match_over, winner;
  logic pl, pr, fb;
  always_comb begin
    pl = bus.ce & sync_l[1] & ~sl;
    pr = bus.ce & (bus.cpu_enable ? (lfsr[3:0] < bus.cpu_level) : (sync_r[1] & ~sr));
    fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sync_l <= '0;
      sync_r <= '0;
      sl <= 1'b0;
      sr <= 1'b0;
      lfsr <= 16'hACE1;
      pos <= PW'(CENTER);
      hold <= '0;
      scorer <= 1'b0;
      led <= CENTER_LED;
      score_l <= '0;
      score_r <= '0;
      match_over <= 1'b0;
      winner <= 1'b0;
    end else begin
      sync_l <= {sync_l[0], bus.btn_left};
      sync_r <= {sync_r[0], bus.btn_right};
      if (bus.ce) begin
        sl <= sync_l[1];
        sr <= sync_r[1];
        lfsr <= {fb, lfsr[15:1]};
      end
      if ((state == IDLE || state == MATCH_OVER) && bus.start) begin
        state <= PLAY;
        pos <= PW'(CENTER);
        led <= CENTER_LED;
        score_l <= '0;
        score_r <= '0;
        match_over <= 1'b0;
      end else if (state == PLAY && pl != pr) begin
        if (pl && pos == PW'(NUM_LEDS - 1)) begin
          state <= POINT;
          scorer <= 1'b0;
          hold <= '0;
          led <= LEFT_EDGE;
          score_l <= score_l + SW'(score_l != SW'(POINTS_TO_WIN));
        end else if (pr && pos == '0) begin
          state <= POINT;
          scorer <= 1'b1;
          hold <= '0;
          led <= RIGHT_EDGE;
          score_r <= score_r + SW'(score_r != SW'(POINTS_TO_WIN));
        end else begin
          pos <= pl ? pos + PW'(1) : pos - PW'(1);
          led <= pl ? led << 1 : led >> 1;
        end
      end else if (state == POINT && bus.ce) begin
        if (hold == HW'(HOLD_TICKS - 1)) begin
          hold <= '0;
          if ((scorer ? score_r : score_l) == SW'(POINTS_TO_WIN)) begin
            state <= MATCH_OVER;
            match_over <= 1'b1;
            winner <= scorer;
            led <= scorer ? RIGHT_WIN : LEFT_WIN;
          end else begin
            state <= PLAY;
            pos <= PW'(CENTER);
            led <= CENTER_LED;
          end
        end else begin
          hold <= hold + HW'(1);
          led <= led ^ (scorer ? RIGHT_EDGE : LEFT_EDGE);
        end
      end
    end
  end
  assign bus.led = led;
  assign bus.score_left = score_l;
  assign bus.score_right = score_r;
  assign bus.match_over = match_over;
  assign bus.winner = winner;
endmodule
